// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU control decoder and the multicycle ALU:
//   op-code values, op-code width and the ALU sequencing FSM encoding.
//   Keeping the codes here means the decoder and the datapath cannot drift.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI = 4'b0010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'b0100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_t;

    function automatic logic alu_is_shift(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
//   Iterative one-bit-per-cycle logical shifter used for SLL/SRL when the
//   barrel shifter is not built. Holds the shift register and the remaining
//   step count; o_last flags the step that produces the final value.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   i_load   in   load i_data / i_shamt (start of a shift op)
//   i_step   in   perform one shift step and decrement the count
//   i_op     in   latched op code; ALU_SLL shifts left, anything else right
//   i_data   in   operand A to shift
//   i_shamt  in   shift amount (non-zero when loaded)
//   o_next   out  shift register value after the current step
//   o_last   out  high when the current step is the final one
// ---------------------------------------------------------------------------
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic                    i_step,
    input  logic [ALU_OP_WIDTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [SHAMT_WIDTH-1:0]  i_shamt,
    output logic [DATA_WIDTH-1:0]   o_next,
    output logic                    o_last
);

    logic [DATA_WIDTH-1:0]  r_shreg;
    logic [SHAMT_WIDTH-1:0] r_count;

    // Logical shifts: zero fill on both sides.
    assign o_next = (i_op == ALU_SLL) ? (r_shreg << 1) : (r_shreg >> 1);
    assign o_last = (r_count == SHAMT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_count <= i_shamt;
        end else if (i_step) begin
            r_shreg <= o_next;
            r_count <= r_count - SHAMT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Datapath ALU stage behind the ALU control decoder. A request is taken
//   on start_i in IDLE; ADD/SUB/LUI/OR (and undefined codes, which yield 0)
//   finish in one cycle. SLL/SRL run through an iterative shifter, one bit
//   per cycle, unless ALU_BARREL_SHIFT_EN is defined, in which case they
//   are computed combinationally like the other ops.
//
// Optional build macro: ALU_BARREL_SHIFT_EN
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-low reset
//   start_i          in   request, sampled only in IDLE
//   ALU_Operation_i  in   4-bit op code (see alu_pkg)
//   A_i              in   operand A
//   B_i              in   operand B (shift amount in B_i[SHAMT_WIDTH-1:0])
//   busy_o           out  high while not IDLE (SHIFT and DONE)
//   done_o           out  one-cycle pulse, result valid
//   ALU_Result_o     out  result, held until the next completion
//   Zero_o           out  ALU_Result_o == 0, registered with the result
// ---------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [ALU_OP_WIDTH-1:0] ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0]   A_i,
    input  logic [DATA_WIDTH-1:0]   B_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   ALU_Result_o,
    output logic                    Zero_o
);

    alu_state_t             r_state;
    alu_state_t             w_state_next;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_zero;
    logic [DATA_WIDTH-1:0]  w_fast_result;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic                   w_fast_wr;
    logic                   w_busy;
    logic                   w_done;

`ifndef ALU_BARREL_SHIFT_EN
    logic [ALU_OP_WIDTH-1:0] r_op;
    logic                    w_load;
    logic                    w_shift_wr;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_shift_next;
`endif

    assign w_shamt = B_i[SHAMT_WIDTH-1:0];

    // Single-cycle result, computed straight from the request inputs so it
    // can be written on the same edge that accepts the request.
    always_comb begin
        w_fast_result = '0;
        case (ALU_Operation_i)
            ALU_ADD: w_fast_result = A_i + B_i;
            ALU_SUB: w_fast_result = A_i + (~B_i) + DATA_WIDTH'(1);
            ALU_LUI: w_fast_result = B_i;
            ALU_OR:  w_fast_result = A_i | B_i;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: w_fast_result = A_i << w_shamt;
            ALU_SRL: w_fast_result = A_i >> w_shamt;
`else
            // Only reaches the result register when the shift amount is 0.
            ALU_SLL: w_fast_result = A_i;
            ALU_SRL: w_fast_result = A_i;
`endif
            default: w_fast_result = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_fast_wr    = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        w_load       = 1'b0;
        w_shift_wr   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start_i) begin
                    w_state_next = ST_DONE;
                    w_fast_wr    = 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
                    if (alu_is_shift(ALU_Operation_i) && (w_shamt != '0)) begin
                        w_state_next = ST_SHIFT;
                        w_fast_wr    = 1'b0;
                        w_load       = 1'b1;
                    end
`endif
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                // The step with one bit left produces the final value.
                if (w_last) begin
                    w_state_next = ST_DONE;
                    w_shift_wr   = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result and zero flag, updated only on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_fast_wr) begin
            r_result <= w_fast_result;
            r_zero   <= (w_fast_result == '0);
        end
`ifndef ALU_BARREL_SHIFT_EN
        else if (w_shift_wr) begin
            r_result <= w_shift_next;
            r_zero   <= (w_shift_next == '0);
        end
`endif
    end

`ifndef ALU_BARREL_SHIFT_EN
    // Op is latched so the shifter direction is immune to input changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= '0;
        end else if (w_load) begin
            r_op <= ALU_Operation_i;
        end
    end

    alu_shift_iter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift_iter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_step  (r_state == ST_SHIFT),
        .i_op    (r_op),
        .i_data  (A_i),
        .i_shamt (w_shamt),
        .o_next  (w_shift_next),
        .o_last  (w_last)
    );
`endif

    assign busy_o       = w_busy;
    assign done_o       = w_done;
    assign ALU_Result_o = r_result;
    assign Zero_o       = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Directed bench for alu_multicycle. Expected results come from a small
//   reference model, are queued when a request is driven and are checked
//   when done_o pulses. Honours ALU_BARREL_SHIFT_EN for shift latency.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    typedef struct {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (op_i),
        .A_i             (a_i),
        .B_i             (b_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (result_o),
        .Zero_o          (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return b;
            4'd3:    return a | b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((op == 4'd4 || op == 4'd5) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res  = model(op, a, b);
        e.zero = (e.res == 32'd0);
        exp_q.push_back(e);
    endtask

    // Called #1 after the edge that accepted the request.
    task automatic wait_done(input int lat, input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (done_o !== 1'b1 && cyc < 40) begin
            chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd1);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_sb_nonempty"}, {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, result_o, e.res);
            chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, e.zero});
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        push_exp(op, a, b);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        // Scramble inputs: the latched request must not see them.
        op_i = 4'($urandom_range(0, 15));
        a_i  = $urandom;
        b_i  = $urandom;
        wait_done(exp_latency(op, b), tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int dones;
        int exp_dones;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        start_i = 1'b0;
        op_i    = 4'd0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        do_op(4'd1, 32'd5, 32'd5, "sub_zero");
        do_op(4'd1, 32'd3, 32'd5, "sub_neg");
        do_op(4'd4, 32'h0000_0001, 32'hFFFF_FFFF, "sll_31");
        do_op(4'd5, 32'h8000_0000, 32'd4, "srl_4");
        do_op(4'd5, 32'hDEAD_BEEF, 32'h0000_0020, "srl_0");
        do_op(4'd4, 32'h8000_0001, 32'h0000_0021, "sll_1");
        do_op(4'd2, 32'h0000_0000, 32'h1234_5000, "lui");
        do_op(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, "or");
        do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, "undef_op");

        // start_i held high through a busy SLL while an ADD is presented.
        push_exp(4'd4, 32'd3, 32'd8);
        op_i    = 4'd4;
        a_i     = 32'd3;
        b_i     = 32'd8;
        start_i = 1'b1;
        @(posedge clk); #1;
        push_exp(4'd0, 32'd10, 32'd20);
        op_i = 4'd0;
        a_i  = 32'd10;
        b_i  = 32'd20;
        wait_done(exp_latency(4'd4, 32'd8), "held_sll");
        @(posedge clk); #1;
        chk("held_gap_done", {31'd0, done_o}, 32'd0);
        chk("held_gap_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(1, "held_add");
        @(posedge clk); #1;
        chk("held_add_end", {31'd0, done_o}, 32'd0);

        // Reset asserted in the middle of a long SLL.
        op_i    = 4'd4;
        a_i     = 32'd1;
        b_i     = 32'd20;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        dones = 0;
        if (done_o) dones++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
`ifdef ALU_BARREL_SHIFT_EN
        exp_dones = 1;
`else
        exp_dones = 0;
        chk("midrst_pre_busy", {31'd0, busy_o}, 32'd1);
`endif
        chk("midrst_no_done", dones, exp_dones);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_zero", {31'd0, zero_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_done", {31'd0, done_o}, 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_after_done", {31'd0, done_o}, 32'd0);
            chk("midrst_after_busy", {31'd0, busy_o}, 32'd0);
        end
        do_op(4'd0, 32'd100, 32'd23, "add_after_rst");

        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            do_op(rop, ra, rb, "rand");
        end

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
